mmio_store_capture: RTL and testbench

//  Snoops the data-memory store bus (memWrite/address/writeData) of the single-cycle 16-bit MIPS computer.

---
 rtl/mmio_store_capture_if.sv | 34 +++
 rtl/mmio_store_capture.sv | 141 ++++++++++++++
 tb/tb_mmio_store_capture.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_store_capture_if.sv
// Store-bus snoop and result-stream bundle for mmio_store_capture.
// slave: capture-unit side; master: computer/consumer side.
interface mmio_store_capture_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              memWrite;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writeData;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;

   modport master (
      output memWrite,
      output address,
      output writeData,
      output out_ready,
      input  out_valid,
      input  out_addr,
      input  out_data
   );

   modport slave (
      input  memWrite,
      input  address,
      input  writeData,
      input  out_ready,
      output out_valid,
      output out_addr,
      output out_data
   );
endinterface

// File: rtl/mmio_store_capture.sv
// Captures CPU stores to a result window into a FWFT FIFO and flags halt.
// Ports: clk, rst (async, active-low), bus (slave modport: store snoop
// memWrite/address/writeData plus out_valid/out_ready/out_addr/out_data
// stream), level (occupancy), overflow (sticky drop), done (halt+drained).
// Optional macro STORE_CAPTURE_STATS_EN adds saturating stat_captured and
// stat_dropped counters.
module mmio_store_capture #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
   parameter logic [ADDR_W-1:0] SPAN      = 16'h0040,
   parameter logic [ADDR_W-1:0] HALT_ADDR = 16'h0000,
   parameter int                DEPTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   mmio_store_capture_if.slave      bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     done
`ifdef STORE_CAPTURE_STATS_EN
   ,
   output logic [15:0]              stat_captured,
   output logic [15:0]              stat_dropped
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
   // One extra bit so the upper bound never wraps.
   localparam logic [ADDR_W:0] HI = {1'b0, BASE_ADDR} + {1'b0, SPAN};

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      FIN
   } state_t;

   state_t state;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic [ADDR_W:0] addr_x;
   logic            in_win;
   logic            hit;
   logic            is_halt;
   logic            pop;
   logic            full;
   logic            push;
   logic            drop;

   assign addr_x  = {1'b0, bus.address};
   assign in_win  = (addr_x >= LO) && (addr_x < HI);
   assign hit     = bus.memWrite && in_win && (state == RUN);
   assign is_halt = bus.memWrite && (bus.address == HALT_ADDR)
                    && (state == RUN);

   assign bus.out_valid = (level != '0);
   // Head reads as zero while empty so the idle bus is quiet.
   assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr] : '0;
   assign bus.out_data  = bus.out_valid ? data_mem[rd_ptr] : '0;

   assign pop  = bus.out_valid && bus.out_ready;
   assign full = (level == FULL);
   // When full, a same-edge pop frees the slot the push overwrites.
   assign push = hit && (!full || pop);
   assign drop = hit && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= bus.address;
         data_mem[wr_ptr] <= bus.writeData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
         state    <= RUN;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + (PW+1)'(1);
            2'b01:   level <= level - (PW+1)'(1);
            default: level <= level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
         case (state)
            RUN: begin
               if (is_halt) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (level == '0 && !push) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               done <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

`ifdef STORE_CAPTURE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_captured <= '0;
         stat_dropped  <= '0;
      end else begin
         if (push && stat_captured != 16'hFFFF) begin
            stat_captured <= stat_captured + 16'd1;
         end
         if (drop && stat_dropped != 16'hFFFF) begin
            stat_dropped <= stat_dropped + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mmio_store_capture.sv
// Scoreboard bench for mmio_store_capture: directed scenarios plus
// randomized store/ready traffic against a queue-based reference model.
module tb_mmio_store_capture;

   localparam int DEPTH = 8;
   localparam int BASE  = 'h0000;
   localparam int SPAN  = 'h0040;
   localparam int HALT  = 'h0000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] level;
   logic       overflow;
   logic       done;
`ifdef STORE_CAPTURE_STATS_EN
   logic [15:0] stat_captured;
   logic [15:0] stat_dropped;
`endif

   mmio_store_capture_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mmio_store_capture #(
      .ADDR_W(16), .DATA_W(16),
      .BASE_ADDR(16'h0000), .SPAN(16'h0040),
      .HALT_ADDR(16'h0000), .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .level(level),
      .overflow(overflow),
      .done(done)
`ifdef STORE_CAPTURE_STATS_EN
      ,
      .stat_captured(stat_captured),
      .stat_dropped(stat_dropped)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } st_t;

   st_t         sb[$];
   int          mlevel = 0;
   bit          movf = 1'b0;
   int          mphase = 0;
   int          mcap = 0;
   int          mdrop = 0;
   logic [15:0] last_pop = '0;
   int          checks = 0;
   int          errors = 0;

   function automatic bit in_win(int a);
      return (a >= BASE) && (a < BASE + SPAN);
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   // Reference model: decides at each edge what the window/FIFO/halt rules
   // make of the store on the bus, and queues accepted stores.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb.delete();
         mlevel = 0;
         movf   = 1'b0;
         mphase = 0;
         mcap   = 0;
         mdrop  = 0;
      end else begin
         bit pop_e;
         bit cap_e;
         bit acc_e;
         pop_e = (mlevel > 0) && bus.out_ready;
         cap_e = (mphase == 0) && bus.memWrite
                 && in_win(int'(bus.address));
         acc_e = cap_e && ((mlevel < DEPTH) || pop_e);
         if (mphase == 1 && mlevel == 0) mphase = 2;
         if (mphase == 0 && bus.memWrite && int'(bus.address) == HALT)
            mphase = 1;
         if (acc_e) begin
            sb.push_back({bus.address, bus.writeData});
            if (mcap < 'hFFFF) mcap++;
         end else if (cap_e) begin
            movf = 1'b1;
            if (mdrop < 'hFFFF) mdrop++;
         end
         mlevel = mlevel + int'(acc_e) - int'(pop_e);
      end
   end

   // Monitor: compares DUT outputs to the model, pops on accepted heads.
   always @(negedge clk) begin
      chk("level", 32'(level), mlevel);
      chk("out_valid", 32'(bus.out_valid), 32'(mlevel > 0));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("done", 32'(done), 32'(mphase == 2));
`ifdef STORE_CAPTURE_STATS_EN
      chk("stat_captured", 32'(stat_captured), mcap);
      chk("stat_dropped", 32'(stat_dropped), mdrop);
`endif
      if (!rst) begin
         chk("rst_out_addr", 32'(bus.out_addr), 0);
         chk("rst_out_data", 32'(bus.out_data), 0);
      end else if (bus.out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_head got=%0h want=none t=%0t",
                     bus.out_data, $time);
         end else begin
            chk("head_addr", 32'(bus.out_addr), 32'(sb[0].a));
            chk("head_data", 32'(bus.out_data), 32'(sb[0].d));
            if (bus.out_ready) begin
               last_pop = sb[0].d;
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [15:0] a, input logic [15:0] d);
      bus.memWrite  = 1'b1;
      bus.address   = a;
      bus.writeData = d;
      cyc();
      bus.memWrite = 1'b0;
   endtask

   task automatic wait_empty(input int maxc);
      bus.out_ready = 1'b1;
      for (int i = 0; i < maxc && level != 0; i++) cyc();
      chk("drain_bound", 32'(level), 0);
   endtask

   task automatic wait_done(input int maxc);
      bus.out_ready = 1'b1;
      for (int i = 0; i < maxc && !done; i++) cyc();
      chk("done_bound", 32'(done), 1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.memWrite  = 1'($urandom);
         bus.address   = 16'($urandom);
         bus.writeData = 16'($urandom);
         bus.out_ready = 1'($urandom);
         cyc();
      end
      bus.memWrite  = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      cyc();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.memWrite  = 1'b0;
      bus.address   = '0;
      bus.writeData = '0;
      bus.out_ready = 1'b0;

      // Reset held with a noisy bus
      do_reset(6);
      chk("t1_valid", 32'(bus.out_valid), 0);
      chk("t1_level", 32'(level), 0);
      chk("t1_ovf", 32'(overflow), 0);
      chk("t1_done", 32'(done), 0);

      // Single store, one-cycle latency
      put(16'h0004, 16'h00AB);
      chk("t2_valid", 32'(bus.out_valid), 1);
      chk("t2_addr", 32'(bus.out_addr), 'h0004);
      chk("t2_data", 32'(bus.out_data), 'h00AB);
      chk("t2_level", 32'(level), 1);
      wait_empty(20);
      bus.out_ready = 1'b0;

      // Window edges
      put(16'h0040, 16'h0001);
      put(16'hFFFF, 16'h0002);
      put(16'h003F, 16'h0003);
      chk("t3_level", 32'(level), 1);
      chk("t3_addr", 32'(bus.out_addr), 'h003F);

      // Reset mid-operation discards contents
      put(16'h0008, 16'h0011);
      put(16'h0009, 16'h0012);
      rst = 1'b0;
      #2;
      chk("rst_mid_level", 32'(level), 0);
      chk("rst_mid_valid", 32'(bus.out_valid), 0);
      rst = 1'b1;
      cyc();

      // Fill then overflow
      for (int i = 1; i <= 9; i++)
         put(16'($urandom_range(1, 63)), 16'(i));
      chk("t4_level", 32'(level), 8);
      chk("t4_ovf", 32'(overflow), 1);
      wait_empty(30);
      chk("t4_last", 32'(last_pop), 8);
      bus.out_ready = 1'b0;
      do_reset(2);

      // Full with simultaneous pop and push
      for (int i = 1; i <= 8; i++) put(16'(i), 16'(i));
      chk("t5_full", 32'(level), 8);
      bus.out_ready = 1'b1;
      put(16'h0020, 16'h0055);
      chk("t5_level", 32'(level), 8);
      chk("t5_ovf", 32'(overflow), 0);
      wait_empty(30);
      chk("t5_last", 32'(last_pop), 'h0055);

      // Halt sequence
      bus.out_ready = 1'b1;
      put(16'h0010, 16'h0007);
      put(16'h0000, 16'h0037);
      wait_done(30);
      chk("t6_last", 32'(last_pop), 'h0037);
      put(16'h0020, 16'h0009);
      cyc();
      chk("t6_ignored", 32'(level), 0);
      chk("t6_done", 32'(done), 1);

      // Randomized traffic
      do_reset(3);
      for (int i = 0; i < 3000; i++) begin
         int p;
         p = ((i / 200) % 2 == 1) ? 25 : 75;
         bus.out_ready = ($urandom_range(0, 99) < p);
         bus.memWrite  = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 3) == 0)
            bus.address = 16'($urandom_range(64, 65535));
         else
            bus.address = 16'($urandom_range(1, 63));
         bus.writeData = 16'($urandom);
         cyc();
      end
      bus.memWrite = 1'b0;
      bus.out_ready = 1'b1;
      put(16'h0000, 16'hBEEF);
      wait_done(60);
      chk("rand_sb_empty", 32'(sb.size()), 0);
      chk("rand_last", 32'(last_pop), 'hBEEF);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
